// File: rtl/wb_ctrl.sv
// WB_CTRL: sequences the writeback stage through one layer pass.
// Each row gets a fixed burst of wb_en beats followed by a FinishWB
// row-advance gap; the last row is followed by a longer drain so the
// final word write lands. A host can take the BRAM port while idle.
// Every output is registered, decoded from the next state.

module wb_ctrl #(
  parameter int unsigned BEATS_PER_ROW = 36,
  parameter int unsigned ROWS          = 28,
  parameter int unsigned GAP           = 1,
  parameter logic [3:0]  LAYER1        = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] layer_cfg,
  input  logic       pe_valid,
  input  logic       host_req,
  output logic       host_gnt,
  output logic [3:0] Layer,
  output logic       wb_en,
  output logic       FinishWB,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAITV,
    RUN,
    ADV,
    DRAIN,
    DONE
  } state_t;

  // Terminal counts for the 8-bit counters. GAP may legally be zero, in
  // which case the ADV state is skipped entirely.
  localparam logic [7:0] LAST_BEAT  = 8'(BEATS_PER_ROW - 1);
  localparam logic [7:0] LAST_ROW   = 8'(ROWS - 1);
  localparam logic [7:0] LAST_GAP   = 8'(GAP - 1);
  localparam logic [7:0] LAST_DRAIN = 8'd2;

  state_t     state;
  state_t     state_next;
  logic [7:0] beat_cnt;
  logic [7:0] beat_next;
  logic [7:0] row_cnt;
  logic [7:0] row_next;
  logic [7:0] phase_cnt;
  logic [7:0] phase_next;
  logic [3:0] layer_next;
  logic       err_next;
  logic       start_ok;
  logic       start_bad;

  // A start only counts while the host does not own the port; a start
  // for an unsupported layer is rejected and flagged instead.
  assign start_ok  = start && !host_gnt && (layer_cfg == LAYER1);
  assign start_bad = start && !host_gnt && (layer_cfg != LAYER1);

  // Next-state and next-counter logic for the pass sequencer.
  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    row_next   = row_cnt;
    phase_next = phase_cnt;
    layer_next = Layer;
    err_next   = err;

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD;
          layer_next = layer_cfg;
          row_next   = 8'd0;
          beat_next  = 8'd0;
          phase_next = 8'd0;
          err_next   = 1'b0;
        end else if (start_bad) begin
          err_next = 1'b1;
        end
      end

      LOAD: begin
        state_next = WAITV;
      end

      WAITV: begin
        if (pe_valid) begin
          state_next = RUN;
          beat_next  = 8'd0;
        end
      end

      RUN: begin
        // The row never stalls: dropping wb_en mid-row would reset the
        // writeback packing state, so a missing pe_valid is only flagged.
        if (!pe_valid) begin
          err_next = 1'b1;
        end
        if (beat_cnt == LAST_BEAT) begin
          phase_next = 8'd0;
          if (row_cnt == LAST_ROW) begin
            state_next = DRAIN;
          end else begin
            row_next = row_cnt + 8'd1;
            if (GAP == 0) begin
              state_next = WAITV;
            end else begin
              state_next = ADV;
            end
          end
        end else begin
          beat_next = beat_cnt + 8'd1;
        end
      end

      ADV: begin
        if (phase_cnt == LAST_GAP) begin
          state_next = WAITV;
          phase_next = 8'd0;
        end else begin
          phase_next = phase_cnt + 8'd1;
        end
      end

      DRAIN: begin
        if (phase_cnt == LAST_DRAIN) begin
          state_next = DONE;
          phase_next = 8'd0;
        end else begin
          phase_next = phase_cnt + 8'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the state
  // being entered so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= 8'd0;
      row_cnt   <= 8'd0;
      phase_cnt <= 8'd0;
      Layer     <= 4'd0;
      err       <= 1'b0;
      wb_en     <= 1'b0;
      FinishWB  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      host_gnt  <= 1'b0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_next;
      row_cnt   <= row_next;
      phase_cnt <= phase_next;
      Layer     <= layer_next;
      err       <= err_next;
      wb_en     <= (state_next == RUN);
      FinishWB  <= (state_next == ADV) || (state_next == DRAIN);
      busy      <= (state_next != IDLE) && (state_next != DONE);
      done      <= (state_next == DONE);
      host_gnt  <= host_req && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with BEATS_PER_ROW=4, ROWS=2, GAP=1.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_wb_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] layer_cfg;
  logic       pe_valid;
  logic       host_req;
  logic       host_gnt;
  logic [3:0] Layer;
  logic       wb_en;
  logic       FinishWB;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;

  wb_ctrl #(
    .BEATS_PER_ROW(4),
    .ROWS         (2),
    .GAP          (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .layer_cfg(layer_cfg),
    .pe_valid (pe_valid),
    .host_req (host_req),
    .host_gnt (host_gnt),
    .Layer    (Layer),
    .wb_en    (wb_en),
    .FinishWB (FinishWB),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] l,
                               input logic pv, input logic hr);
    start     = s;
    layer_cfg = l;
    pe_valid  = pv;
    host_req  = hr;
  endtask

  function automatic logic [9:0] outs();
    return {host_gnt, Layer, wb_en, FinishWB, busy, done, err};
  endfunction

  // Hand-derived pass waveform {busy, wb_en, FinishWB, done} for cycle c
  // after the start edge: LOAD, WAITV, 4xRUN, ADV, WAITV, 4xRUN,
  // 3xDRAIN, DONE, IDLE.
  function automatic logic [3:0] expectedTrace(input int c);
    if (c <= 2)       return 4'b1000;
    else if (c <= 6)  return 4'b1100;
    else if (c == 7)  return 4'b1010;
    else if (c == 8)  return 4'b1000;
    else if (c <= 12) return 4'b1100;
    else if (c <= 15) return 4'b1010;
    else if (c == 16) return 4'b0001;
    else              return 4'b0000;
  endfunction

  // One full pass started from IDLE on the current falling edge.
  task automatic runPass(input string name, input logic drop_pv,
                         input logic hold_req, input logic exp_err);
    int         wb_count;
    logic       pv;
    logic [4:0] exp_vec;
    wb_count = 0;
    applyStimulus(1'b1, 4'd1, 1'b1, hold_req);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_vec = {hold_req && (c == 17), expectedTrace(c)};
      checkOutput($sformatf("%s_c%0d", name, c),
                  32'({host_gnt, busy, wb_en, FinishWB, done}), 32'(exp_vec));
      if (wb_en) wb_count++;
      if (c == 1)  checkOutput({name, "_err_clear"}, 32'(err), 0);
      if (c == 16) checkOutput({name, "_layer"}, 32'(Layer), 1);
      pv = !(drop_pv && (c == 4 || c == 5));
      applyStimulus(1'b0, 4'd1, pv, hold_req);
    end
    checkOutput({name, "_wb_total"}, wb_count, 8);
    checkOutput({name, "_err_end"}, 32'(err), 32'(exp_err));
  endtask

  // Main directed sequence.
  initial begin
    logic seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #7;
    checkOutput("reset_outs", 32'(outs()), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_outs", 32'(outs()), 0);

    $display("[TB] basic pass");
    runPass("basic", 1'b0, 1'b0, 1'b0);

    $display("[TB] unsupported layer");
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bad_err", 32'(err), 1);
    checkOutput("bad_busy", 32'(busy), 0);
    applyStimulus(1'b0, 4'd3, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | wb_en | busy;
    end
    checkOutput("bad_no_wb", 32'(seen), 0);
    checkOutput("bad_err_sticky", 32'(err), 1);

    $display("[TB] pe_valid drop mid-row");
    runPass("pv_drop", 1'b1, 1'b0, 1'b1);

    $display("[TB] start and host_req tie");
    runPass("host_tie", 1'b0, 1'b1, 1'b0);

    $display("[TB] start while host owns port");
    applyStimulus(1'b1, 4'd1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("gnt_start_busy", 32'(busy), 0);
    checkOutput("gnt_start_wb", 32'({wb_en, FinishWB}), 0);
    checkOutput("gnt_start_err", 32'(err), 0);
    checkOutput("gnt_still", 32'(host_gnt), 1);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("gnt_bad_err", 32'(err), 0);
    checkOutput("gnt_bad_busy", 32'(busy), 0);
    applyStimulus(1'b0, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("gnt_release", 32'(host_gnt), 0);

    $display("[TB] reset during second row");
    applyStimulus(1'b1, 4'd1, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 4'd1, 1'b1, 1'b0);
    end
    checkOutput("rst_pre_wb", 32'(wb_en), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_outs", 32'(outs()), 0);
    @(negedge clk);
    checkOutput("rst_held_outs", 32'(outs()), 0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    checkOutput("rst_no_done", 32'(seen), 0);
    runPass("after_rst", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter BEATS_PER_ROW, default 36: wb_en-high cycles per output row.
REQ-002 Parameter ROWS, default 28: output rows per layer pass.
REQ-003 Parameter GAP, default 1: FinishWB-high cycles between rows.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset (`RstEnable = 0).
REQ-006 start  in  1  one-cycle pass request; sampled only in IDLE.
REQ-007 layer_cfg  in  4  requested layer code.
REQ-008 pe_valid  in  1  PE groups are presenting valid sums.
REQ-009 host_req  in  1  host requests ownership of the BRAM32k port.
REQ-010 host_gnt  out  1  host owns the BRAM32k port.
REQ-011 Layer  out  4  layer code driven to writeback.
REQ-012 wb_en  out  1  writeback accumulate enable.
REQ-013 FinishWB  out  1  writeback row-advance strobe.
REQ-014 busy  out  1  pass in progress (any state other than IDLE or DONE).
REQ-015 done  out  1  one-cycle pass-complete pulse.
REQ-016 err  out  1  sticky error flag; cleared only by reset or by an accepted start.

Function
REQ-017 All outputs shall be registered.
REQ-018 FSM states: IDLE, LOAD, WAITV, RUN, ADV, DRAIN, DONE.
REQ-019 IDLE to LOAD when start=1, layer_cfg=`Layer1 and host_gnt=0; Layer <= layer_cfg, row_cnt <= 0, err <= 0.
REQ-020 start with layer_cfg != `Layer1 in IDLE shall set err=1 and remain in IDLE.
REQ-021 LOAD to WAITV unconditionally, one cycle.
REQ-022 WAITV to RUN on the first cycle pe_valid=1; beat_cnt <= 0.
REQ-023 RUN: wb_en=1 and FinishWB=0 for exactly BEATS_PER_ROW consecutive cycles, regardless of pe_valid.
REQ-024 pe_valid=0 during RUN shall set err=1 without stalling or aborting the row (dropping wb_en would reset writeback's packing state).
REQ-025 End of RUN with row_cnt < ROWS-1: go to ADV, row_cnt++.
REQ-026 End of RUN with row_cnt = ROWS-1: go to DRAIN.
REQ-027 ADV: wb_en=0, FinishWB=1 for exactly GAP cycles, then to WAITV.
REQ-028 DRAIN: wb_en=0, FinishWB=1 for 3 cycles, so writeback completes its final word write; then to DONE.
REQ-029 DONE: done=1 for one cycle, Layer held; then to IDLE.
REQ-030 Counters are 8 bits; beat_cnt and row_cnt never wrap within a pass (BEATS_PER_ROW and ROWS both at most 255).
REQ-031 host_gnt <= 1 only in IDLE with host_req=1 and no same-cycle valid start (start wins a tie).
REQ-032 host_gnt <= 0 the cycle after host_req falls.
REQ-033 While host_gnt=1: start is ignored (no err) and wb_en=FinishWB=0.
REQ-034 host_req while busy shall wait; grant is given no earlier than the cycle after DONE.
REQ-035 Total wb_en-high cycles per pass = ROWS x BEATS_PER_ROW.

Reset
REQ-036 On rst=0, asynchronously: state=IDLE; Layer=0; counters 0; wb_en, FinishWB, busy, done, err and host_gnt all 0.
REQ-037 Reset asserted mid-pass shall abort immediately with no done pulse; a new start is accepted after release.

Verification
REQ-038 BEATS=4, ROWS=2, GAP=1; start with layer_cfg=`Layer1 and pe_valid=1 -> wb_en high 4, FinishWB 1, wb_en 4, FinishWB 3, done 1 cycle; busy low after done.
REQ-039 layer_cfg=4'd3 with start -> err=1, busy stays 0, no wb_en.
REQ-040 pe_valid low 2 cycles mid-RUN -> err=1, wb_en stays high the full 4 beats, pass completes with done.
REQ-041 start and host_req in the same IDLE cycle -> pass runs, host_gnt=0 throughout, host_gnt=1 the cycle after DONE.
REQ-042 rst pulsed low during second-row RUN -> all outputs 0 immediately, no done; subsequent start completes normally.
REQ-043 host_gnt=1 and start pulsed -> start ignored, err=0, wb_en=0.
